fifo_uart_drain: RTL and testbench
==================================

// Module: fifo_uart_drain
// PURPOSE
//  Downstream consumer of the WL-bit sample FIFO. Pops one word at a time via a
//  single-cycle read request, captures the registered FIFO output and serialises
//  it on an asynchronous UART-style line (start, WL data LSB-first, opt. parity, stop).
//  Sits between the FIFO read port and the board TX pin / host link.
// PARAMETERS
//  WL           10   data word width; must equal FIFO WL
//  CLKS_PER_BIT 868  CLK cycles per serial bit (100 MHz / 115200); >= 2
//  PARITY_EN    0    1 = append even-parity bit after data, 0 = none
// PORTS
//  CLK          in   1       system clock, all logic on posedge
//  RST          in   1       synchronous, active-high reset
//  en           in   1       1 = allowed to start new words
//  fifo_empty   in   1       FIFO empty flag
//  fifo_error   in   1       FIFO error flag (registered, valid with fifo_dout)
//  fifo_dout    in   WL      FIFO registered read data
//  fifo_rReq    out  1       read request to FIFO, one-cycle pulse, registered
//  tx           out  1       serial line, idle high
//  busy         out  1       1 whenever state != IDLE
//  word_done    out  1       one-cycle pulse at end of each stop bit
//  drop_cnt     out  8       words discarded on fifo_error, saturates at 255
// BEHAVIOUR
//  Reset: tx=1, fifo_rReq=0, busy=0, word_done=0, drop_cnt=0, state IDLE,
//   baud/bit counters 0. RST mid-frame aborts: tx=1 after that edge, word lost.
//  FSM: IDLE -> REQ -> LOAD -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  Edge E0: IDLE with en=1 && fifo_empty=0 -> REQ, fifo_rReq<=1.
//  Edge E1: FIFO consumes request; -> LOAD, fifo_rReq<=0. Exactly one pulse/word.
//  Edge E2 (LOAD): fifo_error=1 -> drop word, drop_cnt+1 (sat.), -> IDLE, tx stays 1.
//   else shift_reg<=fifo_dout, parity<=^fifo_dout, tx<=0, -> START.
//  Every bit state holds tx for exactly CLKS_PER_BIT cycles; baud counter
//   0..CLKS_PER_BIT-1, restarts on each state/bit change.
//  DATA: bit index 0..WL-1, tx=shift_reg[idx]; after idx WL-1 -> PARITY
//   (PARITY_EN=1, tx=parity) or STOP (tx=1).
//  STOP end: word_done=1 that cycle, -> IDLE. IDLE re-samples on next edge.
//  Word period back-to-back = (2+WL+PARITY_EN)*CLKS_PER_BIT + 3 cycles.
//  fifo_empty is sampled only in IDLE; never request while empty.
//  en=0 mid-frame: current frame completes; no new REQ until en=1.
//  en is don't-care outside IDLE; fifo_dout/error are don't-care outside LOAD.
//  Bit counter width $clog2(WL+1); baud counter width $clog2(CLKS_PER_BIT).
// STRUCTURE
//  Shared include fifo_link_pkg: FSM state localparams (3-bit), TX_IDLE=1'b1,
//   default WL shared with the FIFO.
//  Sub-module baud_tick_gen #(CLKS_PER_BIT): clr in, tick out (pulse on last
//   cycle of a bit). Top holds FSM, shift reg, parity, drop counter.
// TESTING (WL=10, CLKS_PER_BIT=4 unless stated)
//  1 Reset: hold RST 3 cycles, fifo_empty=0 -> tx=1, fifo_rReq=0, drop_cnt=0, busy=0.
//  2 One word 10'h2A5, PARITY_EN=0 -> single rReq pulse; tx: 0, 1,0,1,0,0,1,0,1,0,1,
//    then 1, each 4 cycles; word_done 48 cycles after tx falls.
//  3 Three words queued -> exactly 3 rReq pulses, 51 cycles apart, data in order.
//  4 fifo_error=1 in LOAD -> no tx activity, drop_cnt=1, back in IDLE 1 cycle later.
//  5 en->0 during DATA of word 1, fifo_empty=0 -> word 1 completes, no further rReq.
//  6 PARITY_EN=1, word 10'h2A5 -> parity bit 1, frame 52 cycles; RST mid-DATA ->
//    tx=1 and busy=0 on next cycle.

Source files
------------

// File: rtl/fifo_link_pkg.sv
// Definitions shared between the sample FIFO and its UART drain:
// FSM encoding, serial idle level and the common data word width.
package fifo_link_pkg;

    localparam int unsigned WL_DEFAULT = 10;
    localparam logic        TX_IDLE    = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_LOAD   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } drain_state_e;

endpackage

// File: rtl/fifo_uart_drain_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// clr holds the count at zero so every bit state starts a fresh period.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick = (cnt_q == LAST) && !clr;

endmodule

// File: rtl/fifo_uart_drain.sv
// Pops one word at a time from the sample FIFO and serialises it as
// start, WL data bits LSB-first, optional even parity, stop.
module fifo_uart_drain
    import fifo_link_pkg::*;
#(
    parameter int unsigned WL           = WL_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic          fifo_error,
    input  logic [WL-1:0] fifo_dout,
    output logic          fifo_rReq,
    output logic          tx,
    output logic          busy,
    output logic          word_done,
    output logic [7:0]    drop_cnt
);

    localparam int unsigned BW = $clog2(WL + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WL - 1);

    drain_state_e  state_q;
    logic          rreq_q;
    logic          tx_q;
    logic          word_done_q;
    logic [7:0]    drop_q;
    logic [WL-1:0] shift_q;
    logic          parity_q;
    logic [BW-1:0] bit_idx_q;

    logic baud_clr;
    logic baud_tick;

    assign baud_clr = (state_q == ST_IDLE) || (state_q == ST_REQ) || (state_q == ST_LOAD);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .CLK (CLK),
        .RST (RST),
        .clr (baud_clr),
        .tick(baud_tick)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            rreq_q      <= 1'b0;
            tx_q        <= TX_IDLE;
            word_done_q <= 1'b0;
            drop_q      <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            bit_idx_q   <= '0;
        end else begin
            rreq_q      <= 1'b0;
            word_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (en && !fifo_empty) begin
                        rreq_q  <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: state_q <= ST_LOAD;
                ST_LOAD: begin
                    if (fifo_error) begin
                        if (drop_q != '1) drop_q <= drop_q + 8'd1;
                        state_q <= ST_IDLE;
                    end else begin
                        shift_q  <= fifo_dout;
                        parity_q <= ^fifo_dout;
                        tx_q     <= 1'b0;
                        state_q  <= ST_START;
                    end
                end
                // Data leaves via shift_q[0]; the register shifts right so the
                // current bit is always at index 0 rather than muxed by bit_idx_q.
                ST_START: begin
                    if (baud_tick) begin
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                        bit_idx_q <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_idx_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_q;
                                state_q <= ST_PARITY;
                            end else begin
                                tx_q    <= TX_IDLE;
                                state_q <= ST_STOP;
                            end
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + BW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx_q    <= TX_IDLE;
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        word_done_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign fifo_rReq = rreq_q;
    assign tx        = tx_q;
    assign busy      = (state_q != ST_IDLE);
    assign word_done = word_done_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fifo_uart_drain.sv
// Directed bench for fifo_uart_drain: one instance without parity, one with,
// each fed by a small registered-read FIFO model.
module tb_fifo_uart_drain;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       en  = 1'b0;
    logic       e0 = 1'b1, e1 = 1'b1;
    logic       er0 = 1'b0, er1 = 1'b0;
    logic [9:0] d0 = '0, d1 = '0;
    logic       r0, r1, tx0, tx1, b0, b1, wd0, wd1;
    logic [7:0] dc0, dc1;

    always #5 CLK = ~CLK;

    fifo_uart_drain #(.WL(10), .CLKS_PER_BIT(4), .PARITY_EN(0)) u_np (
        .CLK(CLK), .RST(RST), .en(en), .fifo_empty(e0), .fifo_error(er0), .fifo_dout(d0),
        .fifo_rReq(r0), .tx(tx0), .busy(b0), .word_done(wd0), .drop_cnt(dc0));

    fifo_uart_drain #(.WL(10), .CLKS_PER_BIT(4), .PARITY_EN(1)) u_par (
        .CLK(CLK), .RST(RST), .en(en), .fifo_empty(e1), .fifo_error(er1), .fifo_dout(d1),
        .fifo_rReq(r1), .tx(tx1), .busy(b1), .word_done(wd1), .drop_cnt(dc1));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    logic [10:0] q0[$], q1[$];
    int unsigned rlog0[$], wdlog0[$];
    logic        txlog0[0:4095];

    typedef struct {
        logic [9:0]  data;
        logic        err;
        logic        par;
        int unsigned nbits;
        logic [12:0] frame;     // bit 0 = start bit, sent first
        logic [7:0]  drop_exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        logic pr0, pr1;
        pr0 = r0;
        pr1 = r1;
        @(posedge CLK);
        #1;
        cyc++;
        if (pr0) begin
            chk("req_nonempty_np", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) {er0, d0} = q0.pop_front();
            e0 = (q0.size() == 0);
        end
        if (pr1) begin
            chk("req_nonempty_par", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) {er1, d1} = q1.pop_front();
            e1 = (q1.size() == 0);
        end
        if (cyc < 4096) txlog0[cyc] = tx0;
        if (r0)  rlog0.push_back(cyc);
        if (wd0) wdlog0.push_back(cyc);
    endtask

    task automatic push(input logic dut, input logic [9:0] data, input logic err);
        if (dut) begin q1.push_back({err, data}); e1 = 1'b0; end
        else     begin q0.push_back({err, data}); e0 = 1'b0; end
    endtask

    task automatic wait_req(input logic dut);
        int n = 0;
        while ((dut ? r1 : r0) !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(dut ? "req_seen_par" : "req_seen_np", 32'(dut ? r1 : r0), 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic act;
        push(v.par, v.data, v.err);
        wait_req(v.par);
        tick();
        chk($sformatf("v%0d_req_pulse", idx), 32'(v.par ? r1 : r0), 32'd0);
        tick();
        if (v.err) begin
            chk($sformatf("v%0d_err_tx", idx), 32'(v.par ? tx1 : tx0), 32'd1);
            chk($sformatf("v%0d_err_idle", idx), 32'(v.par ? b1 : b0), 32'd0);
            chk($sformatf("v%0d_drop", idx), 32'(v.par ? dc1 : dc0), 32'(v.drop_exp));
        end else begin
            for (int b = 0; b < int'(v.nbits); b++) begin
                act = v.frame[b];
                for (int c = 0; c < 4; c++) begin
                    if ((v.par ? tx1 : tx0) !== v.frame[b] || (v.par ? b1 : b0) !== 1'b1
                        || (v.par ? wd1 : wd0) !== 1'b0)
                        act = ~v.frame[b];
                    tick();
                end
                chk($sformatf("v%0d_bit%0d", idx, b), 32'(act), 32'(v.frame[b]));
            end
            chk($sformatf("v%0d_word_done", idx), 32'(v.par ? wd1 : wd0), 32'd1);
            chk($sformatf("v%0d_tx_idle", idx), 32'(v.par ? tx1 : tx0), 32'd1);
            chk($sformatf("v%0d_busy_low", idx), 32'(v.par ? b1 : b0), 32'd0);
            chk($sformatf("v%0d_drop", idx), 32'(v.par ? dc1 : dc0), 32'(v.drop_exp));
            tick();
            chk($sformatf("v%0d_done_pulse", idx), 32'(v.par ? wd1 : wd0), 32'd0);
        end
    endtask

    function automatic logic [9:0] decode0(input int unsigned st);
        logic [9:0] w;
        for (int b = 0; b < 10; b++) w[b] = txlog0[st + 4 * (b + 1) + 1];
        return w;
    endfunction

    initial begin
        int unsigned base_r, base_w, st;
        logic [9:0] words[3];

        vecs[0] = '{10'h2A5, 1'b0, 1'b0, 12, {1'b0, 1'b1, 10'h2A5, 1'b0}, 8'd0};
        vecs[1] = '{10'h3FF, 1'b0, 1'b0, 12, {1'b0, 1'b1, 10'h3FF, 1'b0}, 8'd0};
        vecs[2] = '{10'h000, 1'b0, 1'b0, 12, {1'b0, 1'b1, 10'h000, 1'b0}, 8'd0};
        vecs[3] = '{10'h2A5, 1'b1, 1'b0, 0,  13'h0,                        8'd1};
        vecs[4] = '{10'h155, 1'b0, 1'b0, 12, {1'b0, 1'b1, 10'h155, 1'b0}, 8'd1};
        vecs[5] = '{10'h2A5, 1'b0, 1'b1, 13, {1'b1, 1'b1, 10'h2A5, 1'b0}, 8'd0};
        vecs[6] = '{10'h001, 1'b0, 1'b1, 13, {1'b1, 1'b1, 10'h001, 1'b0}, 8'd0};
        vecs[7] = '{10'h3FF, 1'b0, 1'b1, 13, {1'b1, 1'b0, 10'h3FF, 1'b0}, 8'd0};
        vecs[8] = '{10'h0F0, 1'b1, 1'b1, 0,  13'h0,                        8'd1};

        // Reset held with a word waiting and en high.
        RST = 1'b1;
        en  = 1'b1;
        push(1'b0, 10'h111, 1'b0);
        repeat (3) tick();
        chk("rst_tx", 32'(tx0), 32'd1);
        chk("rst_rreq", 32'(r0), 32'd0);
        chk("rst_drop", 32'(dc0), 32'd0);
        chk("rst_busy", 32'(b0), 32'd0);
        chk("rst_word_done", 32'(wd0), 32'd0);
        chk("rst_tx_par", 32'(tx1), 32'd1);
        q0.delete();
        e0 = 1'b1;
        RST = 1'b0;
        tick();

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // drop_cnt saturation: np instance already holds 1.
        for (int i = 0; i < 256; i++) begin
            push(1'b0, 10'h0, 1'b1);
            wait_req(1'b0);
            tick();
            tick();
            if (i == 253) chk("drop_at_255", 32'(dc0), 32'd255);
        end
        chk("drop_saturated", 32'(dc0), 32'd255);
        chk("drop_tx_quiet", 32'(tx0), 32'd1);

        // Three queued words back to back.
        words[0] = 10'h123;
        words[1] = 10'h3C0;
        words[2] = 10'h05A;
        base_r = rlog0.size();
        base_w = wdlog0.size();
        for (int k = 0; k < 3; k++) push(1'b0, words[k], 1'b0);
        repeat (170) tick();
        chk("b2b_req_count", rlog0.size() - base_r, 32'd3);
        chk("b2b_done_count", wdlog0.size() - base_w, 32'd3);
        if (rlog0.size() - base_r == 3) begin
            for (int k = 0; k < 3; k++) begin
                st = rlog0[base_r + k] + 2;
                chk($sformatf("b2b_start%0d", k), 32'(txlog0[st]), 32'd0);
                chk($sformatf("b2b_word%0d", k), 32'(decode0(st)), 32'(words[k]));
                if (k > 0)
                    chk($sformatf("b2b_gap%0d", k), rlog0[base_r + k] - rlog0[base_r + k - 1], 32'd51);
            end
        end

        // en dropped during DATA of the first of two queued words.
        base_r = rlog0.size();
        base_w = wdlog0.size();
        push(1'b0, 10'h0F0, 1'b0);
        push(1'b0, 10'h30F, 1'b0);
        wait_req(1'b0);
        st = cyc + 2;
        repeat (12) tick();
        en = 1'b0;
        repeat (80) tick();
        chk("en_req_count", rlog0.size() - base_r, 32'd1);
        chk("en_done_count", wdlog0.size() - base_w, 32'd1);
        chk("en_word", 32'(decode0(st)), 32'h0F0);
        chk("en_idle", 32'(b0), 32'd0);
        q0.delete();
        e0 = 1'b1;
        en = 1'b1;

        // Reset in the middle of a parity-enabled frame.
        push(1'b1, 10'h2A5, 1'b0);
        wait_req(1'b1);
        repeat (2 + 4 + 6) tick();
        chk("midrst_in_data", 32'(b1), 32'd1);
        RST = 1'b1;
        tick();
        chk("midrst_tx", 32'(tx1), 32'd1);
        chk("midrst_busy", 32'(b1), 32'd0);
        chk("midrst_drop_np", 32'(dc0), 32'd0);
        RST = 1'b0;
        q1.delete();
        e1 = 1'b1;
        repeat (5) tick();
        chk("post_rst_tx", 32'(tx1), 32'd1);
        chk("post_rst_req", 32'(r1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
